// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble-serial adder:
//   add_state_t : control FSM states (IDLE, ADD, DONE)
//   NIBBLE_W    : width of one datapath step (the fa4 slice width)
// -----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } add_state_t;

   localparam int NIBBLE_W = 4;

endpackage : adder_pkg

// File: rtl/nibble_serial_adder_fa4.sv
// -----------------------------------------------------------------------------
// fa4
// 4-bit combinational ripple-carry adder, the datapath slice reused by
// nibble_serial_adder.
// Ports:
//   A, B  in  [3:0]  addends
//   Cin   in         carry into bit 0
//   S     out [3:0]  sum bits
//   Cout  out        carry out of bit 3
// -----------------------------------------------------------------------------
module fa4 (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       Cout
);

   logic [4:0] c_s;

   assign c_s[0] = Cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign S[i]     = A[i] ^ B[i] ^ c_s[i];
      assign c_s[i+1] = (A[i] & B[i]) | (c_s[i] & (A[i] ^ B[i]));
   end

   assign Cout = c_s[4];

endmodule : fa4

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Adds two WIDTH-bit operands plus carry-in using a single fa4 slice, one
// nibble per cycle, least-significant nibble first. The inter-nibble carry is
// held in a register. Operands arrive on a valid/ready handshake, the result
// leaves on a second valid/ready handshake.
// WIDTH must be a multiple of 4 and at least 4.
// Ports:
//   clk        in            rising-edge clock
//   nrst       in            asynchronous active-low reset
//   in_valid   in            operands a, b, cin are presented
//   in_ready   out           high only while idle (operands accepted)
//   a, b       in  [WIDTH]   operands
//   cin        in            carry into nibble 0
//   out_valid  out           high only while the result is held
//   out_ready  in            downstream takes the result
//   sum        out [WIDTH]   registered result
//   cout       out           registered carry out of the top nibble
// -----------------------------------------------------------------------------
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   add_state_t             state_q,  state_d;
   logic [WIDTH-1:0]       a_sh_q,   a_sh_d;
   logic [WIDTH-1:0]       b_sh_q,   b_sh_d;
   logic [WIDTH-1:0]       result_q, result_d;
   logic                   carry_q,  carry_d;
   logic [CNT_W-1:0]       cnt_q,    cnt_d;

   logic [NIBBLE_W-1:0]    fa_s;
   logic                   fa_cout;
   // New sum nibble enters at the top; the whole result slides down one
   // nibble, so after NIBBLES steps nibble 0 has reached the bottom.
   logic [WIDTH+NIBBLE_W-1:0] result_wide_s;

   fa4 u_fa4 (
      .A    (a_sh_q[NIBBLE_W-1:0]),
      .B    (b_sh_q[NIBBLE_W-1:0]),
      .Cin  (carry_q),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   assign result_wide_s = {fa_s, result_q};

   // Next-state and datapath update for the IDLE/ADD/DONE sequence.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ADD;
            end else begin
               state_d = IDLE;
            end
         end
         ADD: begin
            result_d = result_wide_s[WIDTH+NIBBLE_W-1:NIBBLE_W];
            a_sh_d   = a_sh_q >> NIBBLE_W;
            b_sh_d   = b_sh_q >> NIBBLE_W;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = ADD;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shift, result, carry and step-counter registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
      end
   end

   // Handshake flags decode directly from the registered state.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = result_q;
   assign cout      = carry_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder: one WIDTH=16 instance driven
// with directed vectors and one WIDTH=4 instance swept over all operands.
// A transaction-level model (sum = a + b + cin, result ready NIBBLES cycles
// after acceptance) is compared against both instances on every falling edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   logic nrst;

   // WIDTH=16 instance signals
   logic        iv16, ir16, ov16, or16, cin16, cout16;
   logic [15:0] a16, b16, sum16;
   // WIDTH=4 instance signals
   logic        iv4, ir4, ov4, or4, cin4, cout4;
   logic [3:0]  a4, b4, sum4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .nrst(nrst), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
      .sum(sum16), .cout(cout16)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .nrst(nrst), .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
      .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // m_st: 0 = waiting for operands, 1 = computing, 2 = holding result
   int          m_st   [2];
   int          m_left [2];
   logic [16:0] m_res  [2];
   logic        iv_a   [2];
   logic        or_a   [2];
   logic [16:0] tot_a  [2];

   assign iv_a[0]  = iv16;
   assign iv_a[1]  = iv4;
   assign or_a[0]  = or16;
   assign or_a[1]  = or4;
   assign tot_a[0] = 17'(a16) + 17'(b16) + 17'(cin16);
   assign tot_a[1] = 17'(a4) + 17'(b4) + 17'(cin4);

   // Model: result is the full sum; it appears NIBBLES edges after acceptance.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 2; i++) begin
            m_st[i]   <= 0;
            m_left[i] <= 0;
            m_res[i]  <= 17'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (m_st[i])
               0: if (iv_a[i]) begin
                     m_res[i]  <= tot_a[i];
                     m_left[i] <= (i == 0) ? 4 : 1;
                     m_st[i]   <= 1;
                  end
               1: begin
                     if (m_left[i] == 1) m_st[i] <= 2;
                     m_left[i] <= m_left[i] - 1;
                  end
               2: if (or_a[i]) m_st[i] <= 0;
               default: m_st[i] <= 0;
            endcase
         end
      end
   end

   // Compare both instances against the model away from the active edge.
   always @(negedge clk) begin
      chk("in_ready16",  ir16, m_st[0] == 0);
      chk("out_valid16", ov16, m_st[0] == 2);
      if (m_st[0] == 2 || !nrst) begin
         chk("model_sum16",  sum16,  m_res[0][15:0]);
         chk("model_cout16", cout16, m_res[0][16]);
      end
      chk("in_ready4",  ir4, m_st[1] == 0);
      chk("out_valid4", ov4, m_st[1] == 2);
      if (m_st[1] == 2 || !nrst) begin
         chk("model_sum4",  sum4,  m_res[1][3:0]);
         chk("model_cout4", cout4, m_res[1][4]);
      end
   end

   // ---------------- directed stimulus ----------------
   // Called #1 after a rising edge with the 16-bit instance idle.
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input int hold);
      int k;
      iv16 = 1'b1; a16 = a; b16 = b; cin16 = c; or16 = (hold == 0);
      @(posedge clk); #1;
      iv16 = 1'b0;
      k = 0;
      while (!ov16 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency16", k, 4);
      chk("sum16", sum16, es);
      chk("cout16", cout16, ec);
      if (hold > 0) begin
         iv16 = 1'b1; a16 = 16'hAAAA;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid16", ov16, 1);
            chk("bp_sum16", sum16, es);
            chk("bp_cout16", cout16, ec);
            chk("bp_in_ready16", ir16, 0);
         end
         iv16 = 1'b0; or16 = 1'b1;
         @(posedge clk); #1;
         chk("release_in_ready16", ir16, 1);
         chk("release_out_valid16", ov16, 0);
         or16 = 1'b0;
      end else begin
         @(posedge clk); #1;
         chk("return_in_ready16", ir16, 1);
      end
   endtask

   // Called #1 after a rising edge with the 4-bit instance idle.
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
      int k;
      logic [4:0] exp;
      exp = 5'(a) + 5'(b) + 5'(c);
      iv4 = 1'b1; a4 = a; b4 = b; cin4 = c; or4 = 1'b1;
      @(posedge clk); #1;
      iv4 = 1'b0;
      k = 0;
      while (!ov4 && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk("latency4", k, 1);
      chk("sum4", {cout4, sum4}, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      nrst = 1'b0;
      iv16 = 1'b0; or16 = 1'b0; cin16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
      iv4  = 1'b0; or4  = 1'b0; cin4  = 1'b0; a4  = 4'h0;  b4  = 4'h0;
      #23;
      chk("rst_in_ready16", ir16, 1);
      chk("rst_out_valid16", ov16, 0);
      chk("rst_sum16", sum16, 16'h0000);
      chk("rst_cout16", cout16, 0);
      nrst = 1'b1;
      @(posedge clk); #1;

      op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
      op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
      op16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
      op16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
      op16(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 5);

      // Abort an operation two nibble steps in.
      iv16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b0; or16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      nrst = 1'b0;
      #1;
      chk("abort_out_valid16", ov16, 0);
      chk("abort_sum16", sum16, 16'h0000);
      chk("abort_cout16", cout16, 0);
      chk("abort_in_ready16", ir16, 1);
      #12;
      nrst = 1'b1;
      @(posedge clk); #1;
      op16(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0);

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int z = 0; z < 2; z++)
               op4(4'(x), 4'(y), 1'(z));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule : tb_nibble_serial_adder
